// File: rtl/sme_host_driver.sv
// Initiator-side driver for the string-match engine: buffers one string and one
// pattern, streams them framed by isstring/ispattern, then captures the result.
module sme_host_driver #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wdata,
   input  logic       str_we,
   input  logic [4:0] str_waddr,
   input  logic       pat_we,
   input  logic [2:0] pat_waddr,
   input  logic [5:0] str_len,
   input  logic [3:0] pat_len,
   input  logic       send_string,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       res_timeout,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       valid,
   input  logic       match,
   input  logic [4:0] match_index
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_STR,
      S_SEND_PAT,
      S_WAIT,
      S_FINISH
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q;
   logic [7:0] str_buf_q [32];
   logic [7:0] pat_buf_q [8];
   logic [5:0] slen_q;
   logic [3:0] plen_q;
   logic [5:0] idx_q;
   logic [7:0] wcnt_q;

   logic       busy_q;
   logic       done_q;
   logic       res_match_q;
   logic [4:0] res_index_q;
   logic       res_timeout_q;
   logic [7:0] chardata_q;
   logic       isstring_q;
   logic       ispattern_q;

   logic [5:0] str_len_c;
   logic [3:0] pat_len_c;
   logic       str_wr_d;
   logic       pat_wr_d;

   assign str_len_c = (str_len > 6'd32) ? 6'd32 : str_len;
   assign pat_len_c = (pat_len > 4'd8)  ? 4'd8  : pat_len;

   // A buffer is locked only while it is the one being streamed out.
   assign str_wr_d = str_we && (state_q != S_SEND_STR);
   assign pat_wr_d = pat_we && (state_q != S_SEND_PAT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) str_buf_q[i] <= 8'h00;
         for (int i = 0; i < 8; i++)  pat_buf_q[i] <= 8'h00;
      end else begin
         if (str_wr_d) str_buf_q[str_waddr] <= wdata;
         if (pat_wr_d) pat_buf_q[pat_waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         slen_q        <= 6'd0;
         plen_q        <= 4'd0;
         idx_q         <= 6'd0;
         wcnt_q        <= 8'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         res_match_q   <= 1'b0;
         res_index_q   <= 5'd0;
         res_timeout_q <= 1'b0;
         chardata_q    <= 8'h00;
         isstring_q    <= 1'b0;
         ispattern_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               chardata_q  <= 8'h00;
               isstring_q  <= 1'b0;
               ispattern_q <= 1'b0;
               if (start && (pat_len_c != 4'd0)) begin
                  busy_q  <= 1'b1;
                  slen_q  <= str_len_c;
                  plen_q  <= pat_len_c;
                  idx_q   <= 6'd0;
                  state_q <= (send_string && (str_len_c != 6'd0)) ? S_SEND_STR : S_SEND_PAT;
               end
            end
            S_SEND_STR: begin
               chardata_q  <= str_buf_q[idx_q[4:0]];
               isstring_q  <= 1'b1;
               ispattern_q <= 1'b0;
               if (idx_q == slen_q - 6'd1) begin
                  idx_q   <= 6'd0;
                  state_q <= S_SEND_PAT;
               end else begin
                  idx_q <= idx_q + 6'd1;
               end
            end
            S_SEND_PAT: begin
               // One extra step after the last character drops the strobes, so
               // WAIT begins on the first cycle with both strobes low.
               if (idx_q < {2'b00, plen_q}) begin
                  chardata_q  <= pat_buf_q[idx_q[2:0]];
                  isstring_q  <= 1'b0;
                  ispattern_q <= 1'b1;
                  idx_q       <= idx_q + 6'd1;
               end else begin
                  chardata_q  <= 8'h00;
                  isstring_q  <= 1'b0;
                  ispattern_q <= 1'b0;
                  wcnt_q      <= 8'd0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (valid) begin
                  res_match_q   <= match;
                  res_index_q   <= match_index;
                  res_timeout_q <= 1'b0;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= S_FINISH;
               end else if (wcnt_q == WAIT_LAST) begin
                  res_match_q   <= 1'b0;
                  res_index_q   <= 5'd0;
                  res_timeout_q <= 1'b1;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= S_FINISH;
               end else begin
                  wcnt_q <= wcnt_q + 8'd1;
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign res_match   = res_match_q;
   assign res_index   = res_index_q;
   assign res_timeout = res_timeout_q;
   assign chardata    = chardata_q;
   assign isstring    = isstring_q;
   assign ispattern   = ispattern_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Directed bench for sme_host_driver: streaming order, framing, result capture,
// timeout, clamping, blocked writes and mid-query reset.
module tb_sme_host_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wdata;
   logic       str_we;
   logic [4:0] str_waddr;
   logic       pat_we;
   logic [2:0] pat_waddr;
   logic [5:0] str_len;
   logic [3:0] pat_len;
   logic       send_string;
   logic       start;
   logic       busy;
   logic       done;
   logic       res_match;
   logic [4:0] res_index;
   logic       res_timeout;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       valid;
   logic       match;
   logic [4:0] match_index;

   int errors = 0;
   int checks = 0;

   logic [7:0] str_m [32];
   logic [7:0] pat_m [8];

   always #5 clk = ~clk;

   sme_host_driver #(.TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .wdata(wdata),
      .str_we(str_we), .str_waddr(str_waddr),
      .pat_we(pat_we), .pat_waddr(pat_waddr),
      .str_len(str_len), .pat_len(pat_len), .send_string(send_string),
      .start(start), .busy(busy), .done(done),
      .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(valid), .match(match), .match_index(match_index)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         str_we = 1'b1; str_waddr = 5'(i); wdata = s[i];
         str_m[i] = s[i];
         step();
      end
      str_we = 1'b0;
   endtask

   task automatic load_pat(input string s);
      for (int i = 0; i < s.len(); i++) begin
         pat_we = 1'b1; pat_waddr = 3'(i); wdata = s[i];
         pat_m[i] = s[i];
         step();
      end
      pat_we = 1'b0;
   endtask

   task automatic pulse_start(input logic snd, input logic [5:0] sl, input logic [3:0] pl);
      send_string = snd; str_len = sl; pat_len = pl; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, res_match, res_index, res_timeout, chardata, isstring, ispattern} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b m=%b i=%0d t=%b cd=%h s=%b p=%b, need all 0",
                  busy, done, res_match, res_index, res_timeout, chardata, isstring, ispattern);
      end
   endtask

   task automatic test_basic();
      logic seen_done;
      load_str("ABCABD");
      load_pat("ABD");
      pulse_start(1'b1, 6'd6, 4'd3);
      str_len = 6'd1; pat_len = 4'd1; send_string = 1'b0;
      checks++;
      if ({busy, isstring, ispattern} !== 3'b100) begin
         errors++; $display("FAIL basic_accept: busy/s/p=%b need 100", {busy, isstring, ispattern});
      end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if ({isstring, ispattern, chardata} !== {2'b10, str_m[i]}) begin
            errors++; $display("FAIL basic_str[%0d]: s/p=%b%b cd=%h need 10 %h", i, isstring, ispattern, chardata, str_m[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({isstring, ispattern, chardata} !== {2'b01, pat_m[i]}) begin
            errors++; $display("FAIL basic_pat[%0d]: s/p=%b%b cd=%h need 01 %h", i, isstring, ispattern, chardata, pat_m[i]);
         end
      end
      step();
      checks++;
      if ({isstring, ispattern, chardata, done, busy} !== 12'b0000_0000_0001) begin
         errors++; $display("FAIL basic_wait_entry: s=%b p=%b cd=%h done=%b busy=%b need 0 0 00 0 1",
                            isstring, ispattern, chardata, done, busy);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++; $display("FAIL basic_early_done: got done before valid, need none");
      end
      valid = 1'b1; match = 1'b1; match_index = 5'd3;
      step();
      valid = 1'b0; match = 1'b0; match_index = 5'd0;
      checks++;
      if ({done, busy, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 1'b1, 5'd3, 1'b0}) begin
         errors++; $display("FAIL basic_result: done=%b busy=%b m=%b i=%0d t=%b need 1 0 1 3 0",
                            done, busy, res_match, res_index, res_timeout);
      end
      step();
      checks++;
      if ({done, busy, res_match, res_index} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
         errors++; $display("FAIL basic_done_pulse: done=%b busy=%b m=%b i=%0d need 0 0 1 3",
                            done, busy, res_match, res_index);
      end
   endtask

   task automatic test_timeout();
      logic seen_done;
      pulse_start(1'b0, 6'd6, 4'd3);
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({isstring, ispattern, busy} !== 3'b001) begin
         errors++; $display("FAIL timeout_wait_entry: s/p/busy=%b need 001", {isstring, ispattern, busy});
      end
      seen_done = 1'b0;
      for (int i = 0; i < 63; i++) begin
         step();
         if (done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++; $display("FAIL timeout_early: done before 64 wait cycles, need none");
      end
      step();
      checks++;
      if ({done, busy, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
         errors++; $display("FAIL timeout_result: done=%b busy=%b m=%b i=%0d t=%b need 1 0 0 0 1",
                            done, busy, res_match, res_index, res_timeout);
      end
      step();
   endtask

   task automatic test_pattern_only();
      logic seen_done;
      load_pat("^B");
      valid = 1'b1; match = 1'b1; match_index = 5'd17;
      pulse_start(1'b0, 6'd6, 4'd2);
      checks++;
      if ({isstring, ispattern, done} !== 3'b000) begin
         errors++; $display("FAIL patonly_accept: s/p/done=%b need 000", {isstring, ispattern, done});
      end
      seen_done = 1'b0;
      step();
      if (done) seen_done = 1'b1;
      checks++;
      if ({isstring, ispattern, chardata} !== {2'b01, 8'h5E}) begin
         errors++; $display("FAIL patonly_c0: s/p=%b%b cd=%h need 01 5e", isstring, ispattern, chardata);
      end
      step();
      if (done) seen_done = 1'b1;
      checks++;
      if ({isstring, ispattern, chardata} !== {2'b01, 8'h42}) begin
         errors++; $display("FAIL patonly_c1: s/p=%b%b cd=%h need 01 42", isstring, ispattern, chardata);
      end
      step();
      if (done) seen_done = 1'b1;
      checks++;
      if (seen_done !== 1'b0 || {isstring, ispattern} !== 2'b00) begin
         errors++; $display("FAIL patonly_valid_ignored: done_seen=%b s/p=%b%b need 0 00", seen_done, isstring, ispattern);
      end
      step();
      valid = 1'b0; match = 1'b0; match_index = 5'd0;
      checks++;
      if ({done, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd17, 1'b0}) begin
         errors++; $display("FAIL patonly_first_wait_valid: done=%b m=%b i=%0d t=%b need 1 1 17 0",
                            done, res_match, res_index, res_timeout);
      end
      step();
   endtask

   task automatic test_clamp();
      logic seen;
      int scnt, pcnt, cyc;
      pulse_start(1'b1, 6'd4, 4'd0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (busy || done || isstring || ispattern) seen = 1'b1;
         step();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL clamp_patlen0: got busy/done/strobe activity, need none");
      end
      for (int i = 0; i < 32; i++) begin
         str_we = 1'b1; str_waddr = 5'(i); wdata = 8'h20 + 8'(i);
         str_m[i] = 8'h20 + 8'(i);
         step();
      end
      str_we = 1'b0;
      load_pat("abcdefgh");
      pulse_start(1'b1, 6'd40, 4'd15);
      scnt = 0; pcnt = 0; cyc = 0;
      while (cyc < 60) begin
         step();
         cyc++;
         pat_we = 1'b0;
         if (isstring) begin
            checks++;
            if (ispattern || pcnt != 0 || chardata !== str_m[scnt % 32]) begin
               errors++; $display("FAIL clamp_str[%0d]: p=%b cd=%h need 0 %h", scnt, ispattern, chardata, str_m[scnt % 32]);
            end
            scnt++;
         end else if (ispattern) begin
            checks++;
            if (chardata !== pat_m[pcnt % 8]) begin
               errors++; $display("FAIL clamp_pat[%0d]: cd=%h need %h", pcnt, chardata, pat_m[pcnt % 8]);
            end
            pcnt++;
            pat_we = 1'b1; pat_waddr = 3'd0; wdata = 8'hFF;
         end else if (pcnt > 0) begin
            break;
         end
      end
      checks++;
      if (scnt != 32 || pcnt != 8) begin
         errors++; $display("FAIL clamp_counts: str=%0d pat=%0d need 32 8", scnt, pcnt);
      end
      valid = 1'b1; match = 1'b0; match_index = 5'd5;
      step();
      valid = 1'b0;
      checks++;
      if ({done, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 5'd5, 1'b0}) begin
         errors++; $display("FAIL clamp_result: done=%b m=%b i=%0d t=%b need 1 0 5 0", done, res_match, res_index, res_timeout);
      end
      step();
      pulse_start(1'b0, 6'd0, 4'd1);
      step();
      checks++;
      if ({ispattern, chardata} !== {1'b1, 8'h61}) begin
         errors++; $display("FAIL blocked_pat_write: p=%b cd=%h need 1 61", ispattern, chardata);
      end
      step();
      valid = 1'b1;
      step();
      valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic seen;
      load_str("XYZW");
      pulse_start(1'b1, 6'd4, 4'd2);
      step();
      step();
      checks++;
      if ({isstring, chardata} !== {1'b1, 8'h59}) begin
         errors++; $display("FAIL rstmid_before: s=%b cd=%h need 1 59", isstring, chardata);
      end
      reset = 1'b0;
      step();
      checks++;
      if ({isstring, ispattern, chardata, busy, done} !== 12'd0) begin
         errors++; $display("FAIL rstmid_after: s=%b p=%b cd=%h busy=%b done=%b need all 0",
                            isstring, ispattern, chardata, busy, done);
      end
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (done || busy || isstring || ispattern) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rstmid_quiet: activity after reset, need none");
      end
      pulse_start(1'b0, 6'd0, 4'd2);
      step();
      checks++;
      if ({ispattern, chardata} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL rstmid_buf_cleared: p=%b cd=%h need 1 00", ispattern, chardata);
      end
      step(); step();
      valid = 1'b1; match = 1'b0; match_index = 5'd0;
      step();
      valid = 1'b0;
      step();
      load_pat("QR");
      pulse_start(1'b0, 6'd0, 4'd2);
      step();
      checks++;
      if ({ispattern, chardata} !== {1'b1, 8'h51}) begin
         errors++; $display("FAIL rstmid_requery_c0: p=%b cd=%h need 1 51", ispattern, chardata);
      end
      step();
      checks++;
      if ({ispattern, chardata} !== {1'b1, 8'h52}) begin
         errors++; $display("FAIL rstmid_requery_c1: p=%b cd=%h need 1 52", ispattern, chardata);
      end
      step();
      valid = 1'b1; match = 1'b1; match_index = 5'd30;
      step();
      valid = 1'b0;
      checks++;
      if ({done, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd30, 1'b0}) begin
         errors++; $display("FAIL rstmid_requery_result: done=%b m=%b i=%0d t=%b need 1 1 30 0",
                            done, res_match, res_index, res_timeout);
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; wdata = 8'h00; str_we = 1'b0; str_waddr = 5'd0;
      pat_we = 1'b0; pat_waddr = 3'd0; str_len = 6'd0; pat_len = 4'd0;
      send_string = 1'b0; start = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
      for (int i = 0; i < 32; i++) str_m[i] = 8'h00;
      for (int i = 0; i < 8; i++)  pat_m[i] = 8'h00;
      step();
      step();
      test_reset();
      reset = 1'b1;
      step();
      test_basic();
      test_timeout();
      test_pattern_only();
      test_clamp();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sme_host_driver.md
Name: sme_host_driver

Overview:
- Initiator-side driver for the string-match engine's character-stream interface.
- A host loads one string (up to 32 chars) and one pattern (up to 8 chars) into local buffers. On start, the block streams the string (optional) and then the pattern, framed by isstring/ispattern.
- It then waits for the engine's valid and captures match/match_index into result registers with a done pulse.
- Used as the front end of the match subsystem and as a reusable stimulus driver in system benches.

Parameters:
- TIMEOUT, 64, number of WAIT cycles without valid before the query is aborted as timed out (legal range 2..255).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- wdata  input  8  host write data for the buffers
- str_we  input  1  write wdata into string buffer at str_waddr
- str_waddr  input  5  string buffer address 0..31
- pat_we  input  1  write wdata into pattern buffer at pat_waddr
- pat_waddr  input  3  pattern buffer address 0..7
- str_len  input  6  string length 0..32; values above 32 are clamped to 32
- pat_len  input  4  pattern length 1..8; values above 8 are clamped to 8
- send_string  input  1  1 = send string phase before pattern; 0 = pattern only (engine reuses its last string)
- start  input  1  single-cycle query request
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the result registers update
- res_match  output  1  captured match
- res_index  output  5  captured match_index
- res_timeout  output  1  1 = query aborted by timeout
- chardata  output  8  character to engine
- isstring  output  1  string character strobe
- ispattern  output  1  pattern character strobe
- valid  input  1  engine result valid
- match  input  1  engine match result
- match_index  input  5  engine match position

Behaviour:
- All outputs are registered.
- Reset values: busy, done, res_match, res_index, res_timeout, chardata, isstring and ispattern are all 0. Buffers are cleared to 8'h00. The FSM enters IDLE.
- States:
  - IDLE: waits for start.
  - SEND_STR: streams the string.
  - SEND_PAT: streams the pattern.
  - WAIT: waits for valid.
  - FINISH: updates results.
- Start acceptance:
  - start is accepted only in IDLE and only when the clamped pat_len is at least 1. Otherwise it is ignored with no done pulse.
  - str_len, pat_len and send_string are latched on acceptance; later changes have no effect on the running query.
- Transition out of IDLE:
  - The FSM goes to SEND_STR if send_string=1 and the clamped str_len is at least 1; otherwise it goes to SEND_PAT.
- SEND_STR timing:
  - If start is accepted at edge T, the first string character drives chardata with isstring=1 from edge T+1.
  - Index 0 is sent first, and one character is sent per cycle for exactly str_len cycles.
  - The FSM then goes directly to SEND_PAT with no gap cycle.
- SEND_PAT:
  - Drives pat_buf[0..pat_len-1] with ispattern=1, one character per cycle.
- Framing rules:
  - isstring and ispattern are never high together.
  - chardata is 0 whenever both strobes are low.
- WAIT:
  - Entered on the edge after the last pattern character; both strobes are low.
  - valid is sampled every WAIT cycle, including the first one. valid while in SEND_STR or SEND_PAT is ignored.
  - When valid=1, match and match_index are captured into res_match/res_index, res_timeout is set to 0, and the FSM goes to FINISH.
  - The wait counter is 8 bits and is cleared on entering WAIT. If it reaches TIMEOUT-1 with valid still low, the block sets res_match=0, res_index=0, res_timeout=1 and goes to FINISH.
  - If valid arrives in the same cycle the timeout would fire, valid wins.
- FINISH:
  - done=1 for exactly one cycle and busy drops in the same cycle; the FSM then returns to IDLE.
  - Result registers hold until the next done.
  - A new start may be accepted in the cycle after FINISH.
- Buffer writes:
  - Writes are accepted in any state except SEND_STR (string buffer writes blocked) and SEND_PAT (pattern buffer writes blocked).
  - Blocked writes are dropped silently.
  - str_we and pat_we may be high together; both writes occur.
- Reset mid-query:
  - At the first edge with reset=0, strobes drop to 0, the FSM goes to IDLE and buffers clear.
  - No done pulse is generated.

Test Plan:
- Load string "ABCABD" (len 6) and pattern "ABD" (len 3), send_string=1, pulse start, and model the engine returning valid 4 cycles after the last ispattern with match=1, index=3. Required: isstring high exactly 6 cycles with chardata 41,42,43,41,42,44; ispattern high exactly 3 cycles immediately after; done one cycle later; res_match=1, res_index=3, res_timeout=0.
- send_string=0 with pattern "^B" (len 2). Required: no isstring cycles; ispattern high 2 cycles starting at the edge after start with chardata 5E,42.
- Engine never asserts valid, TIMEOUT=64. Required: done fires exactly 64 cycles after WAIT entry with res_timeout=1, res_match=0, res_index=0.
- valid high on the first WAIT cycle. Required: captured result; done one cycle later.
- Out-of-range inputs and busy-time writes: start with pat_len=0 produces no busy/done; str_len=40 sends 32 chars; pat_we during SEND_PAT leaves the buffer unchanged.
- reset=0 asserted mid SEND_STR. Required: isstring=0 next edge, busy=0, no done; a subsequent query completes normally.
